// File: rtl/frame_scan_controller.sv
// Frame sequencer for the pixel-pair read path: start-up delay, per-row sync gap,
// then one pixel pair per accepted beat, with incrementally maintained addresses.
module frame_scan_controller #(
    parameter int IMAGE_WIDTH           = 768,
    parameter int IMAGE_HEIGHT          = 512,
    parameter int STARTUP_DELAY         = 100,
    parameter int HORIZONTAL_SYNC_DELAY = 160,
    parameter int BOTTOM_UP             = 1,
    parameter int ROW_WIDTH             = 9,
    parameter int COL_WIDTH             = 9,
    parameter int ADDR_WIDTH            = 19,
    parameter int DELAY_WIDTH           = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  sink_ready,
    output logic                  vertical_Pulse,
    output logic                  horizontal_Pulse,
    output logic                  pixel_valid,
    output logic [ROW_WIDTH-1:0]  row,
    output logic [COL_WIDTH-1:0]  col,
    output logic [ADDR_WIDTH-1:0] even_Addr,
    output logic [ADDR_WIDTH-1:0] odd_Addr,
    output logic                  busy,
    output logic                  done_Flag
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_VSYNC = 3'd1,
        S_HSYNC = 3'd2,
        S_DATA  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam int VS_CYC = (STARTUP_DELAY < 1) ? 1 : STARTUP_DELAY;
    localparam int HS_CYC = (HORIZONTAL_SYNC_DELAY < 1) ? 1 : HORIZONTAL_SYNC_DELAY;
    localparam logic [DELAY_WIDTH-1:0] VS_LAST  = DELAY_WIDTH'(VS_CYC - 1);
    localparam logic [DELAY_WIDTH-1:0] HS_LAST  = DELAY_WIDTH'(HS_CYC - 1);
    localparam logic [COL_WIDTH-1:0]   COL_LAST = COL_WIDTH'(IMAGE_WIDTH / 2 - 1);
    localparam logic [ROW_WIDTH-1:0]   ROW_LAST = ROW_WIDTH'(IMAGE_HEIGHT - 1);
    localparam logic [ADDR_WIDTH-1:0]  ADDR_BASE =
        ADDR_WIDTH'((BOTTOM_UP != 0) ? (IMAGE_HEIGHT - 1) * IMAGE_WIDTH : 0);
    localparam logic [ADDR_WIDTH-1:0]  ADDR_STEP = ADDR_WIDTH'(2);
    // Bottom-up: from the last pair of memory row r to the first pair of row r-1.
    localparam logic [ADDR_WIDTH-1:0]  LINE_BACK = ADDR_WIDTH'(2 * IMAGE_WIDTH - 2);

    state_t                 state_q, state_d;
    logic [DELAY_WIDTH-1:0] dly_q, dly_d;
    logic [ROW_WIDTH-1:0]   row_q, row_d;
    logic [COL_WIDTH-1:0]   col_q, col_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            dly_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
            addr_q  <= ADDR_BASE;
        end else begin
            state_q <= state_d;
            dly_q   <= dly_d;
            row_q   <= row_d;
            col_q   <= col_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dly_d   = dly_q;
        row_d   = row_q;
        col_d   = col_q;
        addr_d  = addr_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (state_q == S_IDLE) begin
                    row_d  = '0;
                    col_d  = '0;
                    addr_d = ADDR_BASE;
                end
                if (start) begin
                    state_d = S_VSYNC;
                    dly_d   = '0;
                    row_d   = '0;
                    col_d   = '0;
                    addr_d  = ADDR_BASE;
                end
            end
            S_VSYNC: begin
                if (dly_q == VS_LAST) begin
                    state_d = S_HSYNC;
                    dly_d   = '0;
                end else begin
                    dly_d = dly_q + 1'b1;
                end
            end
            S_HSYNC: begin
                if (dly_q == HS_LAST) begin
                    state_d = S_DATA;
                    dly_d   = '0;
                end else begin
                    dly_d = dly_q + 1'b1;
                end
            end
            S_DATA: begin
                if (sink_ready) begin
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        if (row_q == ROW_LAST) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_HSYNC;
                            dly_d   = '0;
                            row_d   = row_q + 1'b1;
                            addr_d  = (BOTTOM_UP != 0) ? addr_q - LINE_BACK : addr_q + ADDR_STEP;
                        end
                    end else begin
                        col_d  = col_q + 1'b1;
                        addr_d = addr_q + ADDR_STEP;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign vertical_Pulse   = (state_q == S_HSYNC) || (state_q == S_DATA);
    assign horizontal_Pulse = (state_q == S_DATA);
    assign pixel_valid      = (state_q == S_DATA);
    assign busy             = (state_q == S_VSYNC) || (state_q == S_HSYNC) || (state_q == S_DATA);
    assign done_Flag        = (state_q == S_DONE);
    assign row              = row_q;
    assign col              = col_q;
    assign even_Addr        = addr_q;
    assign odd_Addr         = addr_q + 1'b1;

endmodule
